// File: rtl/rv32_enc_pkg.sv
// Shared constants, format enum and decoded-request record for the RV32I ALU instruction encoder.
package rv32_enc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_B   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef struct packed {
    logic        err;
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } dec_t;

  function automatic logic [2:0] alu_funct3(input logic [3:0] aluop);
    logic [2:0] f3;
    case (aluop)
      ALU_ADD, ALU_SUB: f3 = 3'b000;
      ALU_SLL:          f3 = 3'b001;
      ALU_SLT:          f3 = 3'b010;
      ALU_SLTU:         f3 = 3'b011;
      ALU_XOR:          f3 = 3'b100;
      ALU_SRL, ALU_SRA: f3 = 3'b101;
      ALU_OR:           f3 = 3'b110;
      ALU_AND:          f3 = 3'b111;
      default:          f3 = 3'b000;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/rv32_instr_assembler.sv
// Combinational packing of decoded fields into a 32-bit RV32I word.
// Branch packing is present only when RV32_ENC_BRANCH_EN is defined.
module rv32_instr_assembler
  import rv32_enc_pkg::*;
(
  input  dec_t        dec,
  output logic [31:0] word
);

`ifndef RV32_ENC_BRANCH_EN
  logic unused_imm_s;
  assign unused_imm_s = dec.imm[12];
`endif

  // Field packing per format; illegal requests collapse to NOP
  always_comb begin
    word = NOP;
    if (dec.err) begin
      word = NOP;
    end else begin
      case (dec.fmt)
        FMT_R: word = {dec.funct7, dec.rs2, dec.rs1, dec.funct3, dec.rd, dec.opcode};
        FMT_I: word = {dec.imm[11:0], dec.rs1, dec.funct3, dec.rd, dec.opcode};
`ifdef RV32_ENC_BRANCH_EN
        FMT_B: word = {dec.imm[12], dec.imm[10:5], dec.rs2, dec.rs1, dec.funct3,
                       dec.imm[4:1], dec.imm[11], dec.opcode};
`endif
        default: word = NOP;
      endcase
    end
  end

endmodule

// File: rtl/rv32_alu_instr_encoder.sv
// Two-stage valid/ready encoder: aluop + format + fields -> RV32I instruction word with address/count.
// Branch (fmt=2) encoding is enabled by the RV32_ENC_BRANCH_EN macro.
module rv32_alu_instr_encoder
  import rv32_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_fmt,
  input  logic [3:0]       req_aluop,
  input  logic             req_br_neg,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [12:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_err,
  output logic [31:0]      instr_addr,
  output logic [CNT_W-1:0] instr_count
);

  dec_t             dec_s;
  dec_t             s1_dec_r;
  logic             s1_valid_r;
  logic             fmt_err_s;
  logic             is_shift_s;
  logic             s1_ready_s;
  logic             s2_ready_s;
  logic             out_hs_s;
  logic [31:0]      word_s;
  logic             s2_valid_r;
  logic [31:0]      instr_r;
  logic             err_r;
  logic [31:0]      addr_r;
  logic [CNT_W-1:0] count_r;

  assign s2_ready_s = !s2_valid_r || instr_ready;
  assign s1_ready_s = !s1_valid_r || s2_ready_s;
  assign out_hs_s   = s2_valid_r && instr_ready;
  assign is_shift_s = (req_aluop == ALU_SLL) || (req_aluop == ALU_SRL) || (req_aluop == ALU_SRA);

`ifndef RV32_ENC_BRANCH_EN
  logic unused_br_neg_s;
  assign unused_br_neg_s = req_br_neg;
`endif

  // Request decode: legality plus funct/opcode/immediate fields
  always_comb begin
    dec_s        = '0;
    fmt_err_s    = 1'b0;
    dec_s.fmt    = fmt_e'(req_fmt);
    dec_s.rd     = req_rd;
    dec_s.rs1    = req_rs1;
    dec_s.rs2    = req_rs2;
    dec_s.imm    = req_imm;
    dec_s.funct3 = alu_funct3(req_aluop);
    dec_s.funct7 = 7'b0000000;
    dec_s.opcode = OP_RTYPE;
    case (req_fmt)
      FMT_R: begin
        dec_s.opcode = OP_RTYPE;
        if ((req_aluop == ALU_SUB) || (req_aluop == ALU_SRA)) begin
          dec_s.funct7 = 7'b0100000;
        end else begin
          dec_s.funct7 = 7'b0000000;
        end
      end
      FMT_I: begin
        dec_s.opcode = OP_ITYPE;
        fmt_err_s    = (req_aluop == ALU_SUB);
        // Shift immediates carry funct7 in imm[11:5]; the caller's upper bits are discarded
        if (is_shift_s) begin
          dec_s.imm[11:5] = (req_aluop == ALU_SRA) ? 7'b0100000 : 7'b0000000;
        end else begin
          dec_s.imm[11:5] = req_imm[11:5];
        end
      end
      FMT_B: begin
`ifdef RV32_ENC_BRANCH_EN
        dec_s.opcode = OP_BRANCH;
        case (req_aluop)
          ALU_SUB:  dec_s.funct3 = {2'b00, req_br_neg};
          ALU_SLT:  dec_s.funct3 = {2'b10, req_br_neg};
          ALU_SLTU: dec_s.funct3 = {2'b11, req_br_neg};
          default:  fmt_err_s    = 1'b1;
        endcase
        if (req_imm[0]) begin
          fmt_err_s = 1'b1;
        end else begin
          fmt_err_s = fmt_err_s;
        end
`else
        fmt_err_s = 1'b1;
`endif
      end
      default: fmt_err_s = 1'b1;
    endcase
    dec_s.err = fmt_err_s || (req_aluop > ALU_SLTU);
  end

  // Stage 1: capture the decoded request
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid_r <= 1'b0;
      s1_dec_r   <= '0;
    end else if (s1_ready_s) begin
      s1_valid_r <= req_valid;
      if (req_valid) begin
        s1_dec_r <= dec_s;
      end
    end
  end

  rv32_instr_assembler u_asm (
    .dec  (s1_dec_r),
    .word (word_s)
  );

  // Stage 2: hold the assembled word until downstream accepts it
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s2_valid_r <= 1'b0;
      instr_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else if (s2_ready_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        instr_r <= word_s;
        err_r   <= s1_dec_r.err;
      end
    end
  end

  // Output address and handshake counter, both wrapping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      addr_r  <= BASE_ADDR;
      count_r <= '0;
    end else if (out_hs_s) begin
      addr_r  <= addr_r + 32'd4;
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign req_ready   = s1_ready_s;
  assign instr_valid = s2_valid_r;
  assign instr       = instr_r;
  assign instr_err   = err_r;
  assign instr_addr  = addr_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_rv32_alu_instr_encoder.sv
// Directed self-checking bench for rv32_alu_instr_encoder; expectations follow RV32_ENC_BRANCH_EN.
module tb_rv32_alu_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] NOPW = 32'h0000_0013;
`ifdef RV32_ENC_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_br_neg;
  logic [1:0]  req_fmt;
  logic [3:0]  req_aluop;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [12:0] req_imm;
  logic        instr_valid, instr_ready, instr_err;
  logic [31:0] instr, instr_addr;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  rv32_alu_instr_encoder #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt), .req_aluop(req_aluop),
    .req_br_neg(req_br_neg), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_err(instr_err),
    .instr_addr(instr_addr), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] fmt, input logic [3:0] op, input logic neg,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm);
    req_valid = 1'b1; req_fmt = fmt; req_aluop = op; req_br_neg = neg;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  // Present one request and return just after the edge that accepted it
  task automatic send(input logic [1:0] fmt, input logic [3:0] op, input logic neg,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm, output bit to);
    drive_req(fmt, op, neg, rd, rs1, rs2, imm);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) begin
        tick();
        to = 1'b0;
        break;
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        to = 1'b0;
        break;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; instr_ready = 1'b1;
    req_fmt = 2'd0; req_aluop = 4'd0; req_br_neg = 1'b0;
    req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 13'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", instr_err); end
    checks++; if (instr_addr !== BASE) begin errors++; $display("FAIL reset_addr got %h exp %h", instr_addr, BASE); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", instr_count); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_r_add_latency;
    bit to;
    instr_ready = 1'b1;
    send(2'd0, 4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_accept_timeout got %b exp 0", to); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL add_lat1_valid got %b exp 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL add_lat2_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== 32'h003100B3) begin errors++; $display("FAIL add_instr got %h exp 003100b3", instr); end
    checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", instr_err); end
    checks++; if (instr_addr !== BASE) begin errors++; $display("FAIL add_addr got %h exp %h", instr_addr, BASE); end
    tick();
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d exp 1", instr_count); end
    checks++; if (instr_addr !== BASE + 32'd4) begin errors++; $display("FAIL add_addr_inc got %h exp %h", instr_addr, BASE + 32'd4); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b exp 0", instr_valid); end
  endtask

  task automatic test_r_ops;
    logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [31:0] exp [10] = '{32'h003100B3, 32'h403100B3, 32'h003140B3, 32'h003160B3, 32'h003170B3,
                              32'h003110B3, 32'h003150B3, 32'h403150B3, 32'h003120B3, 32'h003130B3};
    bit to;
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(2'd0, ops[k], 1'b0, 5'd1, 5'd2, 5'd3, 13'h1ABC, to);
      wait_valid(to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL r_op%0d_timeout got %b exp 0", k, to); end
      checks++; if (instr !== exp[k]) begin errors++; $display("FAIL r_op%0d_instr got %h exp %h", k, instr, exp[k]); end
      checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL r_op%0d_err got %b exp 0", k, instr_err); end
      tick();
    end
  endtask

  task automatic test_i_ops;
    logic [3:0]  ops [7] = '{4'd0, 4'd2, 4'd5, 4'd6, 4'd7, 4'd9, 4'd4};
    logic [12:0] imm [7] = '{13'h0FFF, 13'h0123, 13'h1FE5, 13'h0FFF, 13'h1FE3, 13'h0800, 13'h07FF};
    logic [31:0] exp [7] = '{32'hFFF10093, 32'h12314093, 32'h00511093, 32'h01F15093,
                             32'h40315093, 32'h80013093, 32'h7FF17093};
    bit to;
    instr_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(2'd1, ops[k], 1'b0, 5'd1, 5'd2, 5'd9, imm[k], to);
      wait_valid(to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL i_op%0d_timeout got %b exp 0", k, to); end
      checks++; if (instr !== exp[k]) begin errors++; $display("FAIL i_op%0d_instr got %h exp %h", k, instr, exp[k]); end
      checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL i_op%0d_err got %b exp 0", k, instr_err); end
      tick();
    end
  endtask

  task automatic test_branch;
    logic [3:0]  ops [4] = '{4'd1, 4'd1, 4'd8, 4'd9};
    logic        neg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [12:0] imm [4] = '{13'h0008, 13'h0008, 13'h1FFC, 13'h0800};
    logic [31:0] enc [4] = '{32'h00208463, 32'h00209463, 32'hFE20CEE3, 32'h0020F0E3};
    logic [31:0] exp;
    bit to;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = BR_EN ? enc[k] : NOPW;
      send(2'd2, ops[k], neg[k], 5'd31, 5'd1, 5'd2, imm[k], to);
      wait_valid(to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL br%0d_timeout got %b exp 0", k, to); end
      checks++; if (instr !== exp) begin errors++; $display("FAIL br%0d_instr got %h exp %h", k, instr, exp); end
      checks++; if (instr_err !== !BR_EN) begin errors++; $display("FAIL br%0d_err got %b exp %b", k, instr_err, !BR_EN); end
      tick();
    end
  endtask

  task automatic test_illegal;
    logic [1:0]  fmt [5] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd2};
    logic [3:0]  ops [5] = '{4'd1, 4'hC, 4'd0, 4'd0, 4'd1};
    logic [12:0] imm [5] = '{13'h0004, 13'h0000, 13'h0000, 13'h0008, 13'h0009};
    bit to;
    flush = 1'b1; tick(); flush = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(fmt[k], ops[k], 1'b0, 5'd1, 5'd2, 5'd3, imm[k], to);
      wait_valid(to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL ill%0d_timeout got %b exp 0", k, to); end
      checks++; if (instr !== NOPW) begin errors++; $display("FAIL ill%0d_instr got %h exp %h", k, instr, NOPW); end
      checks++; if (instr_err !== 1'b1) begin errors++; $display("FAIL ill%0d_err got %b exp 1", k, instr_err); end
      tick();
      if (k == 1) begin
        checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL ill_count got %0d exp 2", instr_count); end
        checks++; if (instr_addr !== 32'h0000_0000) begin errors++; $display("FAIL ill_addr_wrap got %h exp 00000000", instr_addr); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  fmt [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [3:0]  ops [4] = '{4'd0, 4'd2, 4'd1, 4'd7};
    logic [4:0]  rd  [4] = '{5'd1, 5'd1, 5'd5, 5'd1};
    logic [4:0]  rs1 [4] = '{5'd2, 5'd2, 5'd6, 5'd2};
    logic [4:0]  rs2 [4] = '{5'd3, 5'd0, 5'd7, 5'd0};
    logic [12:0] imm [4] = '{13'h0000, 13'h0123, 13'h0000, 13'h1FE3};
    logic [31:0] exp [4] = '{32'h003100B3, 32'h12314093, 32'h407302B3, 32'h40315093};
    logic [31:0] got [4];
    int idx = 0, nrec = 0, first_cyc = -1, last_cyc = -1;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      instr_ready = (cyc >= 4);
      if (idx < 4) drive_req(fmt[idx], ops[idx], 1'b0, rd[idx], rs1[idx], rs2[idx], imm[idx]);
      else req_valid = 1'b0;
      #1;
      if (cyc == 1) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b exp 1", req_ready); end
      end
      if (cyc == 2 || cyc == 3) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready_c%0d got %b exp 0", cyc, req_ready); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid_c%0d got %b exp 1", cyc, instr_valid); end
        checks++; if (instr !== exp[0]) begin errors++; $display("FAIL b2b_hold_c%0d got %h exp %h", cyc, instr, exp[0]); end
      end
      if (cyc == 4) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got %b exp 1", req_ready); end
      end
      if (req_valid && req_ready) idx++;
      if (instr_valid && instr_ready) begin
        if (nrec < 4) got[nrec] = instr;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nrec++;
      end
      tick();
    end
    req_valid = 1'b0;
    checks++; if (nrec !== 4) begin errors++; $display("FAIL b2b_count_out got %0d exp 4", nrec); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", k, got[k], exp[k]); end
    end
    checks++; if (last_cyc - first_cyc !== 3) begin errors++; $display("FAIL b2b_consecutive got %0d exp 3", last_cyc - first_cyc); end
    checks++; if (instr_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", instr_count); end
    checks++; if (instr_addr !== BASE + 32'd16) begin errors++; $display("FAIL b2b_addr got %h exp %h", instr_addr, BASE + 32'd16); end
  endtask

  task automatic test_flush_reset;
    bit to;
    for (int mode = 0; mode < 2; mode++) begin
      instr_ready = 1'b1;
      send(2'd0, 4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, to);
      wait_valid(to);
      tick();
      instr_ready = 1'b0;
      send(2'd0, 4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, to);
      send(2'd1, 4'd2, 1'b0, 5'd1, 5'd2, 5'd0, 13'h0123, to);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL clr%0d_filled got %b exp 1", mode, instr_valid); end
      drive_req(2'd0, 4'd1, 1'b0, 5'd5, 5'd6, 5'd7, 13'd0);
      instr_ready = 1'b1;
      if (mode == 0) flush = 1'b1; else rst = 1'b1;
      tick();
      flush = 1'b0; rst = 1'b0; req_valid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_valid got %b exp 0", mode, instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL clr%0d_instr got %h exp 0", mode, instr); end
      checks++; if (instr_addr !== BASE) begin errors++; $display("FAIL clr%0d_addr got %h exp %h", mode, instr_addr, BASE); end
      checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL clr%0d_count got %0d exp 0", mode, instr_count); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clr%0d_req_ready got %b exp 1", mode, req_ready); end
      tick(); tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_s1_cleared got %b exp 0", mode, instr_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_r_add_latency();
    test_r_ops();
    test_i_ops();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
